// File: rtl/fetch_ctrl_pkg.sv
// Shared constants and state encoding for the fetch-stage sequencer.
package fetch_ctrl_pkg;

  localparam int unsigned PC_SIZE_DEF    = 32;
  localparam int unsigned INSTR_SIZE_DEF = 32;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;

  // Low PC bits that are always cleared on every next-PC candidate.
  localparam logic [1:0]  INSTR_ALIGN_MASK = 2'b11;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StReq     = 3'd1,
    StWait    = 3'd2,
    StPresent = 3'd3,
    StHold    = 3'd4,
    StDrain   = 3'd5
  } fetch_state_e;

endpackage

// File: rtl/fetch_redirect_arb.sv
// Next-PC priority select: fail > jalr > pred > pc+4, word-aligned, plus redirect flag.
module fetch_redirect_arb
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned PC_SIZE = PC_SIZE_DEF
) (
  input  logic               i_fail_valid,
  input  logic [PC_SIZE-1:0] i_fail_pc,
  input  logic               i_jalr_valid,
  input  logic [PC_SIZE-1:0] i_jalr_pc,
  input  logic               i_pred_valid,
  input  logic [PC_SIZE-1:0] i_pred_pc,
  input  logic [PC_SIZE-1:0] i_pc,
  output logic [PC_SIZE-1:0] o_next_pc,
  output logic               o_redirect
);

  localparam logic [PC_SIZE-1:0] ALIGN_KEEP = ~PC_SIZE'(INSTR_ALIGN_MASK);

  logic [PC_SIZE-1:0] w_target;

  always_comb begin
    w_target   = i_pc + PC_SIZE'(4);
    o_redirect = 1'b0;
    if (i_fail_valid) begin
      w_target   = i_fail_pc;
      o_redirect = 1'b1;
    end else if (i_jalr_valid) begin
      w_target   = i_jalr_pc;
      o_redirect = 1'b1;
    end else if (i_pred_valid) begin
      w_target = i_pred_pc;
    end
    o_next_pc = w_target & ALIGN_KEEP;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, one outstanding imem request, redirect handling.
// Optional FETCH_PERF_EN adds saturating redirect/drain counters.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned        PC_SIZE    = PC_SIZE_DEF,
  parameter int unsigned        INSTR_SIZE = INSTR_SIZE_DEF,
  parameter logic [PC_SIZE-1:0] RESET_PC   = PC_SIZE'(RESET_PC_DEF)
) (
`ifdef FETCH_PERF_EN
  output logic [31:0]           perf_redirect_cnt,
  output logic [31:0]           perf_drain_cnt,
`endif
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  fail_valid,
  input  logic [PC_SIZE-1:0]    fail_pc,
  input  logic                  jalr_valid,
  input  logic [PC_SIZE-1:0]    jalr_pc,
  input  logic                  pred_valid,
  input  logic [PC_SIZE-1:0]    pred_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [PC_SIZE-1:0]    imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INSTR_SIZE-1:0] imem_rsp_instr,
  output logic                  if_valid,
  output logic [INSTR_SIZE-1:0] if_instr,
  output logic [PC_SIZE-1:0]    if_pc
);

  fetch_state_e          r_state, w_state_nxt;
  logic [PC_SIZE-1:0]    r_pc, w_pc_nxt;
  logic                  r_if_valid, w_if_valid_nxt;
  logic [INSTR_SIZE-1:0] r_if_instr;
  logic [PC_SIZE-1:0]    r_if_pc;

  logic                  w_consume;
  logic                  w_capture;
  logic                  w_drop;
  logic                  w_redirect;
  logic [PC_SIZE-1:0]    w_arb_pc;

  // Prediction only matters when decode takes the presented instruction.
  assign w_consume = ((r_state == StPresent) || (r_state == StHold)) && !stall;

  fetch_redirect_arb #(
    .PC_SIZE (PC_SIZE)
  ) u_arb (
    .i_fail_valid (fail_valid),
    .i_fail_pc    (fail_pc),
    .i_jalr_valid (jalr_valid),
    .i_jalr_pc    (jalr_pc),
    .i_pred_valid (pred_valid && w_consume),
    .i_pred_pc    (pred_pc),
    .i_pc         (r_pc),
    .o_next_pc    (w_arb_pc),
    .o_redirect   (w_redirect)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_if_valid_nxt = r_if_valid;
    w_capture      = 1'b0;
    w_drop         = 1'b0;
    case (r_state)
      StIdle: begin
        w_state_nxt = StReq;
        if (w_redirect) w_pc_nxt = w_arb_pc;
      end
      StReq: begin
        if (w_redirect) begin
          w_pc_nxt    = w_arb_pc;
          w_state_nxt = imem_req_ready ? StDrain : StReq;
        end else if (imem_req_ready) begin
          w_state_nxt = StWait;
        end
      end
      StWait: begin
        if (w_redirect) begin
          w_pc_nxt = w_arb_pc;
          if (imem_rsp_valid) begin
            w_drop      = 1'b1;
            w_state_nxt = StReq;
          end else begin
            w_state_nxt = StDrain;
          end
        end else if (imem_rsp_valid) begin
          w_capture      = 1'b1;
          w_if_valid_nxt = 1'b1;
          w_state_nxt    = StPresent;
        end
      end
      StPresent, StHold: begin
        if (w_redirect || !stall) begin
          w_pc_nxt       = w_arb_pc;
          w_if_valid_nxt = 1'b0;
          w_state_nxt    = StReq;
        end else begin
          w_state_nxt = StHold;
        end
      end
      StDrain: begin
        if (w_redirect) w_pc_nxt = w_arb_pc;
        if (imem_rsp_valid) begin
          w_drop      = 1'b1;
          w_state_nxt = StReq;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
    if (w_redirect) w_if_valid_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_pc       <= RESET_PC;
      r_if_valid <= 1'b0;
      r_if_instr <= '0;
      r_if_pc    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_if_valid <= w_if_valid_nxt;
      if (w_capture) begin
        r_if_instr <= imem_rsp_instr;
        r_if_pc    <= r_pc;
      end
    end
  end

  assign imem_req_valid = (r_state == StReq);
  assign imem_req_addr  = r_pc;
  assign if_valid       = r_if_valid;
  assign if_instr       = r_if_instr;
  assign if_pc          = r_if_pc;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_redirect_cnt;
  logic [31:0] r_perf_drain_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_redirect_cnt <= '0;
      r_perf_drain_cnt    <= '0;
    end else begin
      if (w_redirect && (r_perf_redirect_cnt != '1)) begin
        r_perf_redirect_cnt <= r_perf_redirect_cnt + 32'd1;
      end
      if (w_drop && (r_perf_drain_cnt != '1)) begin
        r_perf_drain_cnt <= r_perf_drain_cnt + 32'd1;
      end
    end
  end

  assign perf_redirect_cnt = r_perf_redirect_cnt;
  assign perf_drain_cnt    = r_perf_drain_cnt;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl; imem responses are driven by hand, step by step.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        fail_valid = 1'b0;
  logic [31:0] fail_pc = '0;
  logic        jalr_valid = 1'b0;
  logic [31:0] jalr_pc = '0;
  logic        pred_valid = 1'b0;
  logic [31:0] pred_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_instr = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_redirect_cnt;
  logic [31:0] perf_drain_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .PC_SIZE    (32),
    .INSTR_SIZE (32),
    .RESET_PC   (32'h0000_0000)
  ) dut (
`ifdef FETCH_PERF_EN
    .perf_redirect_cnt (perf_redirect_cnt),
    .perf_drain_cnt    (perf_drain_cnt),
`endif
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .fail_valid     (fail_valid),
    .fail_pc        (fail_pc),
    .jalr_valid     (jalr_valid),
    .jalr_pc        (jalr_pc),
    .pred_valid     (pred_valid),
    .pred_pc        (pred_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_instr (imem_rsp_instr),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered in REQ with ready=1; leaves the DUT in PRESENT with the word on if_*.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] instr);
    chk("req_valid", 64'(imem_req_valid), 64'd1);
    chk("req_addr", 64'(imem_req_addr), 64'(addr));
    step();
    chk("wait_req_valid", 64'(imem_req_valid), 64'd0);
    chk("wait_if_valid", 64'(if_valid), 64'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_instr = instr;
    step();
    imem_rsp_valid = 1'b0;
    chk("pres_if_valid", 64'(if_valid), 64'd1);
    chk("pres_if_pc", 64'(if_pc), 64'(addr));
    chk("pres_if_instr", 64'(if_instr), 64'(instr));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_req_addr", 64'(imem_req_addr), 64'h0);
    chk("rst_if_valid", 64'(if_valid), 64'd0);
    chk("rst_if_instr", 64'(if_instr), 64'h0);
    chk("rst_if_pc", 64'(if_pc), 64'h0);

    rst = 1'b0;
    chk("idle_req_valid", 64'(imem_req_valid), 64'd0);
    imem_req_ready = 1'b1;
    step();

    // Sequential fetches 0x0, 0x4, 0x8, 0xC, 0x10
    fetch(32'h0, 32'hA000_0000);
    step();
    chk("seq_if_valid_drop", 64'(if_valid), 64'd0);
    fetch(32'h4, 32'hA000_0004);
    step();
    fetch(32'h8, 32'hA000_0008);
    step();
    fetch(32'hC, 32'hA000_000C);
    step();
    fetch(32'h10, 32'hA000_0010);

    // Prediction with misaligned target is word-aligned
    pred_valid = 1'b1;
    pred_pc    = 32'h43;
    step();
    pred_valid = 1'b0;
    fetch(32'h40, 32'hA000_0040);
    step();
    chk("seq_after_pred", 64'(imem_req_addr), 64'h44);

    // Mispredict in WAIT, stale response dropped
    step();
    fail_valid = 1'b1;
    fail_pc    = 32'h200;
    step();
    fail_valid = 1'b0;
    chk("drain_req_valid", 64'(imem_req_valid), 64'd0);
    chk("drain_if_valid", 64'(if_valid), 64'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_instr = 32'hDEAD_BEEF;
    step();
    imem_rsp_valid = 1'b0;
    chk("stale_if_valid", 64'(if_valid), 64'd0);
    chk("redir_req_valid", 64'(imem_req_valid), 64'd1);
    chk("redir_req_addr", 64'(imem_req_addr), 64'h200);

    // fail beats jalr in REQ without ready
    imem_req_ready = 1'b0;
    fail_valid = 1'b1;
    fail_pc    = 32'h300;
    jalr_valid = 1'b1;
    jalr_pc    = 32'h500;
    step();
    fail_valid = 1'b0;
    jalr_valid = 1'b0;
    chk("prio_req_valid", 64'(imem_req_valid), 64'd1);
    chk("prio_req_addr", 64'(imem_req_addr), 64'h300);

    // jalr in REQ with ready same cycle -> DRAIN
    imem_req_ready = 1'b1;
    jalr_valid = 1'b1;
    jalr_pc    = 32'h502;
    step();
    jalr_valid = 1'b0;
    chk("jalr_drain_req_valid", 64'(imem_req_valid), 64'd0);
    imem_rsp_valid = 1'b1;
    step();
    imem_rsp_valid = 1'b0;
    chk("jalr_req_addr", 64'(imem_req_addr), 64'h500);
    chk("jalr_if_valid", 64'(if_valid), 64'd0);

    // Redirect in WAIT with response in the same cycle
    step();
    fail_valid = 1'b1;
    fail_pc    = 32'h600;
    imem_rsp_valid = 1'b1;
    imem_rsp_instr = 32'h1111_1111;
    step();
    fail_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    chk("wrsp_if_valid", 64'(if_valid), 64'd0);
    chk("wrsp_req_valid", 64'(imem_req_valid), 64'd1);
    chk("wrsp_req_addr", 64'(imem_req_addr), 64'h600);

    // Stall hold at 0x20; pred during stall must be ignored
    imem_req_ready = 1'b0;
    fail_valid = 1'b1;
    fail_pc    = 32'h20;
    step();
    fail_valid = 1'b0;
    imem_req_ready = 1'b1;
    fetch(32'h20, 32'hB000_0020);
    stall      = 1'b1;
    pred_valid = 1'b1;
    pred_pc    = 32'h80;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_if_valid", 64'(if_valid), 64'd1);
      chk("hold_if_pc", 64'(if_pc), 64'h20);
      chk("hold_if_instr", 64'(if_instr), 64'hB000_0020);
      chk("hold_req_valid", 64'(imem_req_valid), 64'd0);
    end
    stall      = 1'b0;
    pred_valid = 1'b0;
    step();
    chk("unstall_req_valid", 64'(imem_req_valid), 64'd1);
    chk("unstall_req_addr", 64'(imem_req_addr), 64'h24);
    chk("unstall_if_valid", 64'(if_valid), 64'd0);

    // Redirect while held under stall flushes the instruction
    fetch(32'h24, 32'hB000_0024);
    stall = 1'b1;
    step();
    chk("hold2_if_valid", 64'(if_valid), 64'd1);
    fail_valid = 1'b1;
    fail_pc    = 32'h100;
    step();
    fail_valid = 1'b0;
    stall      = 1'b0;
    chk("holdflush_if_valid", 64'(if_valid), 64'd0);
    chk("holdflush_req_addr", 64'(imem_req_addr), 64'h100);

    // PC wrap at top of address space
    imem_req_ready = 1'b0;
    fail_valid = 1'b1;
    fail_pc    = 32'hFFFF_FFFF;
    step();
    fail_valid = 1'b0;
    imem_req_ready = 1'b1;
    chk("top_req_addr", 64'(imem_req_addr), 64'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'hC000_0000);
    step();
    chk("wrap_req_valid", 64'(imem_req_valid), 64'd1);
    chk("wrap_req_addr", 64'(imem_req_addr), 64'h0);

    // Reset mid-WAIT; late response while IDLE ignored
    step();
    rst = 1'b1;
    #1;
    chk("mrst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("mrst_if_valid", 64'(if_valid), 64'd0);
    chk("mrst_if_pc", 64'(if_pc), 64'h0);
    chk("mrst_req_addr", 64'(imem_req_addr), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_instr = 32'hCAFE_F00D;
    step();
    imem_rsp_valid = 1'b0;
    chk("late_if_valid", 64'(if_valid), 64'd0);
    chk("late_req_valid", 64'(imem_req_valid), 64'd1);
    chk("late_req_addr", 64'(imem_req_addr), 64'h0);
    fetch(32'h0, 32'hD000_0000);
    step();
    chk("post_rst_if_valid", 64'(if_valid), 64'd0);
    chk("post_rst_req_addr", 64'(imem_req_addr), 64'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch-stage sequencer that owns the architectural fetch PC. It issues one outstanding instruction-memory request at a time and arbitrates next-PC sources: execute mispredict, decode jalr, predecode jal/bxx-taken prediction, or sequential +4. It discards stale responses after a redirect and holds the fetched instruction under downstream stall. It sits between instruction memory and the predecode/decode boundary.

Parameters:
PC_SIZE, 32, PC/address width
INSTR_SIZE, 32, instruction width
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
stall  in  1  decode cannot accept; hold if_* outputs
fail_valid  in  1  execute reports bxx mispredict
fail_pc  in  PC_SIZE  corrected target
jalr_valid  in  1  decode resolved jalr
jalr_pc  in  PC_SIZE  jalr target
pred_valid  in  1  predecode predicts redirect (jal or bxx taken) for current if_instr
pred_pc  in  PC_SIZE  predicted target
imem_req_valid  out  1  fetch request
imem_req_ready  in  1  request accepted
imem_req_addr  out  PC_SIZE  fetch address
imem_rsp_valid  in  1  response valid (single cycle)
imem_rsp_instr  in  INSTR_SIZE  fetched word
if_valid  out  1  if_instr/if_pc valid to decode
if_instr  out  INSTR_SIZE  instruction
if_pc  out  PC_SIZE  its PC

Behaviour:
- Reset (async, rst=1): state=IDLE, pc_q=RESET_PC, imem_req_valid=0, imem_req_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0. Reset mid-transaction abandons any outstanding request; any response arriving in IDLE is ignored.
- Redirect priority: fail_valid > jalr_valid > pred_valid (pred only consulted when a response is consumed) > pc+4. All targets have bits[1:0] forced to 0. pc+4 wraps modulo 2^PC_SIZE.
- States:
  - IDLE: next cycle -> REQ.
  - REQ: imem_req_valid=1, addr=pc_q. On ready -> WAIT. Address may change before acceptance; imem tolerates withdrawal.
  - WAIT: on rsp_valid, capture if_instr=rsp, if_pc=pc_q, if_valid=1 next cycle, then go to PRESENT.
  - PRESENT: pc_q <= pred_valid ? pred_pc : pc_q+4. If !stall -> REQ, if_valid drops the following cycle unless refilled. If stall -> HOLD.
  - HOLD: if_* stable while stall=1. pred_* is sampled on the cycle stall drops, then -> REQ.
  - DRAIN: a stale request is outstanding. Drop the next rsp_valid without touching if_*, then -> REQ.
- Redirect (fail or jalr) in any state except IDLE: pc_q <= target; if_valid <= 0 next cycle. Next state by current state:
  - REQ without ready: stay REQ.
  - REQ with ready same cycle: DRAIN.
  - WAIT without rsp: DRAIN.
  - WAIT with rsp same cycle: rsp discarded -> REQ.
  - PRESENT/HOLD: -> REQ; stall is ignored, since the held instruction is flushed.
- Redirect in IDLE: pc_q updated, -> REQ.
- Redirect beats a prediction in the same cycle.
- Latency: from acceptance to if_valid = imem latency + 1 cycle. Minimum back-to-back fetch issue is every 3 cycles (REQ, WAIT, PRESENT).
- Exactly one outstanding request at any time.

Optional Feature:
FETCH_PERF_EN. When defined, adds output ports perf_redirect_cnt[31:0] (counts fail/jalr redirects accepted) and perf_drain_cnt[31:0] (counts discarded responses). Both are saturating at all-ones and reset to 0. When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package/defines: PC_SIZE, INSTR_SIZE, RESET_PC default, fetch state encoding (IDLE, REQ, WAIT, PRESENT, HOLD, DRAIN; 3-bit), INSTR_ALIGN_MASK.
- One sub-module: fetch_redirect_arb. Combinational priority select of fail/jalr/pred/+4 producing next_pc and a redirect flag. The FSM and registers stay in fetch_ctrl.

Test Plan:
- Reset release, imem ready=1, 1-cycle rsp -> fetches at 0x0, 0x4, 0x8. if_pc matches; if_valid pulses once per fetch.
- Response at pc 0x10 with pred_valid=1, pred_pc=0x40 -> next imem_req_addr=0x40.
- fail_valid=1, fail_pc=0x200 while in WAIT, then response 0xDEADBEEF -> response dropped, if_valid stays 0, next request addr=0x200.
- fail_valid and jalr_valid both high (0x300 vs 0x500) in REQ -> addr becomes 0x300.
- stall=1 for 5 cycles after if_valid at pc 0x20 -> if_instr/if_pc stable and no new request. stall low with pred_valid=0 -> request at 0x24.
- pc_q=0xFFFF_FFFC, sequential advance -> next request at 0x0000_0000. Assert rst mid-WAIT -> request at RESET_PC after release and late response ignored.
